// File: rtl/dds_sample_capture_if.sv
// Bus and sample-stream bundle between the host/DDS side and the capture buffer.
// Signal names keep the block's published port names.
interface dds_sample_capture_if #(
    parameter int SIG_WIDTH = 16
);
    logic                 i_cap_sample_en;
    logic [SIG_WIDTH-1:0] i_cap_signal;
    logic                 i_cap_write;
    logic                 i_cap_read;
    logic [31:0]          i_cap_addrs;
    logic [31:0]          i_cap_writedata;
    logic [31:0]          o_cap_readdata;
    logic                 o_cap_irq;

    modport master (
        output i_cap_sample_en, i_cap_signal, i_cap_write, i_cap_read,
               i_cap_addrs, i_cap_writedata,
        input  o_cap_readdata, o_cap_irq
    );

    modport slave (
        input  i_cap_sample_en, i_cap_signal, i_cap_write, i_cap_read,
               i_cap_addrs, i_cap_writedata,
        output o_cap_readdata, o_cap_irq
    );
endinterface

// File: rtl/dds_sample_capture.sv
// Captures a programmable number of DDS samples into a FIFO on each sample strobe;
// host arms, polls/gets an irq, and drains the FIFO through the register bus.
module dds_sample_capture #(
    parameter int          SIG_WIDTH = 16,
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0040
) (
    input  logic                  clk,
    input  logic                  a_rst_n,
    dds_sample_capture_if.slave   cap
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [SIG_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]          wptr, rptr, level;
    logic [12:0]          len_reg, len_cap, cnt, level13;
    logic                 irq_en, done_flag, ovf_flag, udf_flag;

    logic       hit, wr, rd, ctrl_wr, stat_wr, arm_cmd, abort_cmd, data_rd;
    logic       empty, full, strobe, push, pop, last, len_zero, busy;
    logic [2:0] sel;
    logic [SIG_WIDTH-1:0] rd_sample;
    logic       unused_bits;

    assign hit       = cap.i_cap_addrs[31:5] == BASE_ADDR[31:5];
    assign sel       = cap.i_cap_addrs[4:2];
    assign wr        = cap.i_cap_write & hit;
    assign rd        = cap.i_cap_read & hit;
    assign ctrl_wr   = wr && (sel == 3'd0);
    assign stat_wr   = wr && (sel == 3'd2);
    assign data_rd   = rd && (sel == 3'd3);
    // ABORT takes priority when both command bits land in one write
    assign abort_cmd = ctrl_wr & cap.i_cap_writedata[1];
    assign arm_cmd   = ctrl_wr & cap.i_cap_writedata[0] & ~cap.i_cap_writedata[1];
    assign len_zero  = len_reg == 13'd0;

    assign empty   = wptr == rptr;
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level   = wptr - rptr;
    assign level13 = 13'(level);
    assign busy    = state == S_CAPTURE;

    // A strobe on the same edge as ARM/ABORT belongs to neither capture
    assign strobe = busy & cap.i_cap_sample_en & ~arm_cmd & ~abort_cmd;
    assign pop    = data_rd & ~empty & ~arm_cmd;
    assign push   = strobe & (~full | pop);
    assign last   = strobe && ((cnt + 13'd1) == len_cap);

    assign rd_sample   = mem[rptr[AW-1:0]];
    assign cap.o_cap_irq = done_flag & irq_en;
    assign unused_bits = ^{cap.i_cap_writedata[31:13], cap.i_cap_addrs[1:0]};

    always_ff @(posedge clk) begin
        if (!a_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (arm_cmd)
                    state_nxt = len_zero ? S_IDLE : S_CAPTURE;
                else if (state == S_DONE && stat_wr && cap.i_cap_writedata[1])
                    state_nxt = S_IDLE;
            end
            S_CAPTURE: begin
                if (abort_cmd)   state_nxt = S_IDLE;
                else if (arm_cmd) state_nxt = len_zero ? S_IDLE : S_CAPTURE;
                else if (last)    state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!a_rst_n) begin
            irq_en    <= 1'b0;
            len_reg   <= '0;
            len_cap   <= '0;
            cnt       <= '0;
            done_flag <= 1'b0;
            ovf_flag  <= 1'b0;
            udf_flag  <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
        end else begin
            if (ctrl_wr) irq_en <= cap.i_cap_writedata[2];
            if (wr && sel == 3'd1) len_reg <= cap.i_cap_writedata[12:0];

            if (stat_wr) begin
                if (cap.i_cap_writedata[1]) done_flag <= 1'b0;
                if (cap.i_cap_writedata[2]) ovf_flag  <= 1'b0;
                if (cap.i_cap_writedata[3]) udf_flag  <= 1'b0;
            end
            if (data_rd && empty)          udf_flag  <= 1'b1;
            if (strobe && full && !pop)    ovf_flag  <= 1'b1;
            if (last)                      done_flag <= 1'b1;
            if (strobe)                    cnt       <= cnt + 13'd1;
            if (push)                      wptr      <= wptr + 1'b1;
            if (pop)                       rptr      <= rptr + 1'b1;

            if (arm_cmd) begin
                wptr    <= '0;
                rptr    <= '0;
                cnt     <= '0;
                len_cap <= len_reg;
                if (len_zero) begin
                    done_flag <= 1'b1;
                end else begin
                    done_flag <= 1'b0;
                    ovf_flag  <= 1'b0;
                    udf_flag  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= cap.i_cap_signal;
    end

    // Registered read port; holds its value until the next hit read
    always_ff @(posedge clk) begin
        if (!a_rst_n) begin
            cap.o_cap_readdata <= '0;
        end else if (rd) begin
            case (sel)
                3'd0:    cap.o_cap_readdata <= {29'd0, irq_en, 2'b00};
                3'd1:    cap.o_cap_readdata <= {19'd0, len_reg};
                3'd2:    cap.o_cap_readdata <= {3'd0, level13, 12'd0,
                                                udf_flag, ovf_flag, done_flag, busy};
                3'd3:    cap.o_cap_readdata <= empty ? 32'd0 : 32'($signed(rd_sample));
                default: cap.o_cap_readdata <= 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_dds_sample_capture.sv
// Directed bench: bus reads push expected data into a scoreboard, a monitor
// compares o_cap_readdata the cycle after each read strobe.
module tb_dds_sample_capture;
    localparam logic [31:0] CTRL = 32'h40, LEN = 32'h44, STAT = 32'h48, DATA = 32'h4C;

    logic clk = 1'b0;
    logic a_rst_n = 1'b0;
    always #5 clk = ~clk;

    dds_sample_capture_if #(.SIG_WIDTH(16)) cap ();

    dds_sample_capture #(
        .SIG_WIDTH(16), .DEPTH(256), .BASE_ADDR(32'h0000_0040)
    ) dut (
        .clk(clk), .a_rst_n(a_rst_n), .cap(cap)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_q = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) rd_q <= cap.i_cap_read;

    always @(negedge clk) begin
        if (rd_q) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard: read data %h with no expected entry", cap.o_cap_readdata);
            end else begin
                check(name_q.pop_front(), cap.o_cap_readdata, exp_q.pop_front());
            end
        end
    end

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        cap.i_cap_write = 1'b1;
        cap.i_cap_addrs = addr;
        cap.i_cap_writedata = data;
        @(negedge clk);
        cap.i_cap_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        @(negedge clk);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        cap.i_cap_read = 1'b1;
        cap.i_cap_addrs = addr;
        @(negedge clk);
        cap.i_cap_read = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] val);
        @(negedge clk);
        cap.i_cap_sample_en = 1'b1;
        cap.i_cap_signal = val;
        @(negedge clk);
        cap.i_cap_sample_en = 1'b0;
    endtask

    task automatic strobe_rd(input logic [15:0] val, input logic [31:0] exp, input string nm);
        @(negedge clk);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        cap.i_cap_sample_en = 1'b1;
        cap.i_cap_signal = val;
        cap.i_cap_read = 1'b1;
        cap.i_cap_addrs = DATA;
        @(negedge clk);
        cap.i_cap_sample_en = 1'b0;
        cap.i_cap_read = 1'b0;
    endtask

    initial begin
        cap.i_cap_sample_en = 1'b0;
        cap.i_cap_signal    = '0;
        cap.i_cap_write     = 1'b0;
        cap.i_cap_read      = 1'b0;
        cap.i_cap_addrs     = '0;
        cap.i_cap_writedata = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("reset_readdata", cap.o_cap_readdata, 32'h0);
        check("reset_irq", {31'd0, cap.o_cap_irq}, 32'h0);
        a_rst_n = 1'b1;
        bus_rd(CTRL, 32'h0, "reset_ctrl");
        bus_rd(LEN,  32'h0, "reset_len");
        bus_rd(STAT, 32'h0, "reset_stat");

        // basic capture of 8 samples, address decode
        bus_wr(LEN, 32'd8);
        bus_wr(32'h84, 32'd5);
        bus_wr(32'h50, 32'd7);
        bus_rd(LEN, 32'd8, "len_nonhit_write");
        bus_rd(32'h50, 32'h0, "other_offset");
        bus_wr(CTRL, 32'h1);
        bus_rd(STAT, 32'h0000_0001, "stat_busy");
        for (int i = 1; i <= 8; i++) strobe(16'(i));
        bus_rd(STAT, 32'h0008_0002, "stat_done8");
        for (int i = 1; i <= 8; i++) bus_rd(DATA, 32'(i), "data8");
        bus_rd(STAT, 32'h0000_0002, "stat_drained");

        // negative sample sign-extension
        bus_wr(STAT, 32'h2);
        bus_wr(LEN, 32'd1);
        bus_wr(CTRL, 32'h1);
        strobe(16'h8000);
        bus_rd(DATA, 32'hFFFF_8000, "data_neg");
        bus_rd(STAT, 32'h0000_0002, "stat_neg");

        // overflow with irq; full push+pop is not an overflow
        bus_wr(LEN, 32'd300);
        bus_wr(CTRL, 32'h5);
        check("irq_armed", {31'd0, cap.o_cap_irq}, 32'h0);
        for (int i = 1; i <= 256; i++) strobe(16'(i));
        bus_rd(STAT, 32'h0100_0001, "stat_full");
        strobe_rd(16'd257, 32'd1, "pop_on_full");
        bus_rd(STAT, 32'h0100_0001, "stat_full_pushpop");
        for (int i = 258; i <= 299; i++) strobe(16'(i));
        check("irq_before_last", {31'd0, cap.o_cap_irq}, 32'h0);
        strobe(16'd300);
        check("irq_done", {31'd0, cap.o_cap_irq}, 32'h1);
        bus_rd(STAT, 32'h0100_0006, "stat_ovf");
        bus_rd(CTRL, 32'h0000_0004, "ctrl_irq_en");
        bus_rd(DATA, 32'd2, "data_after_ovf");
        bus_wr(STAT, 32'h2);
        check("irq_cleared", {31'd0, cap.o_cap_irq}, 32'h0);
        bus_rd(STAT, 32'h00FF_0004, "stat_idle_ovf");

        // LEN=0 arm, underflow, pop on every strobe
        bus_wr(LEN, 32'd0);
        bus_wr(CTRL, 32'h1);
        bus_rd(STAT, 32'h0000_0006, "stat_len0");
        bus_wr(STAT, 32'hE);
        bus_rd(DATA, 32'h0, "data_empty");
        bus_rd(STAT, 32'h0000_0008, "stat_udf");
        bus_wr(STAT, 32'h8);
        bus_wr(LEN, 32'd4);
        bus_wr(CTRL, 32'h1);
        strobe(16'h0011);
        strobe_rd(16'h0022, 32'h11, "stream_pop1");
        strobe_rd(16'h0033, 32'h22, "stream_pop2");
        strobe_rd(16'h0044, 32'h33, "stream_pop3");
        bus_rd(DATA, 32'h44, "stream_pop4");
        bus_rd(STAT, 32'h0000_0002, "stat_stream");

        // abort, arm+abort, re-arm mid capture, LEN latched
        bus_wr(STAT, 32'h2);
        bus_wr(LEN, 32'd10);
        bus_wr(CTRL, 32'h1);
        for (int i = 1; i <= 3; i++) strobe(16'(i));
        bus_wr(CTRL, 32'h3);
        bus_rd(STAT, 32'h0003_0000, "stat_abort");
        bus_wr(CTRL, 32'h1);
        for (int i = 1; i <= 3; i++) strobe(16'(i));
        bus_wr(CTRL, 32'h1);
        bus_rd(STAT, 32'h0000_0001, "stat_rearm");
        bus_wr(LEN, 32'd20);
        for (int i = 1; i <= 7; i++) strobe(16'(i));
        bus_rd(STAT, 32'h0007_0001, "stat_cnt7");
        for (int i = 8; i <= 10; i++) strobe(16'(i));
        bus_rd(STAT, 32'h000A_0002, "stat_cnt10");
        bus_rd(LEN, 32'd20, "len_latched");

        // reset mid-capture
        bus_wr(STAT, 32'h2);
        bus_wr(CTRL, 32'h5);
        strobe(16'h0AAA);
        strobe(16'h0BBB);
        @(negedge clk);
        a_rst_n = 1'b0;
        @(negedge clk);
        a_rst_n = 1'b1;
        check("rst_readdata", cap.o_cap_readdata, 32'h0);
        check("rst_irq", {31'd0, cap.o_cap_irq}, 32'h0);
        strobe(16'h0CCC);
        strobe(16'h0DDD);
        bus_rd(STAT, 32'h0, "rst_stat");
        bus_rd(LEN,  32'h0, "rst_len");
        bus_rd(CTRL, 32'h0, "rst_ctrl");

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected reads never observed, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
